// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store controller driving a 1-cycle registered data memory.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_half,
  output logic        mem_byte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_misalign,
  output logic        resp_illegal,
  output logic        resp_fault,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_data_q, resp_data_d;
  logic        misalign_q, misalign_d, illegal_q, illegal_d, fault_q, fault_d;
  logic        illegal, misalign, fault, in_access;
  logic [31:0] ext;
  always_comb begin
    illegal  = req_store ? (req_funct3 >= 3'b011) : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    fault    = |req_addr[31:ADDR_W];
    // funct3[2] selects zero extension for BU/HU
    ext = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & mem_rdata[7]}}, mem_rdata[7:0]} :
          funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & mem_rdata[15]}}, mem_rdata[15:0]} : mem_rdata;
  end
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    misalign_d  = misalign_q;
    illegal_d   = illegal_q;
    fault_d     = fault_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        store_d     = req_store;
        funct3_d    = req_funct3;
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        resp_data_d = '0;
        illegal_d   = illegal;
        misalign_d  = misalign;
        fault_d     = fault;
        state_d     = (illegal | misalign | fault) ? RESP : ACCESS;
      end
      ACCESS:  state_d = store_q ? RESP : CAPTURE;
      CAPTURE: begin
        resp_data_d = ext;
        state_d     = RESP;
      end
      RESP:    state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
      fault_q     <= fault_d;
    end
  end
  assign in_access     = state_q == ACCESS;
  assign req_ready     = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign resp_valid    = state_q == RESP;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_write     = in_access & store_q;
  assign mem_read      = in_access & ~store_q;
  assign mem_half      = in_access & (funct3_q[1:0] == 2'b01);
  assign mem_byte      = in_access & (funct3_q[1:0] == 2'b00);
  assign resp_data     = resp_data_q;
  assign resp_misalign = misalign_q;
  assign resp_illegal  = illegal_q;
  assign resp_fault    = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-array reference model and a registered-read memory.
module tb_load_store_unit;
  logic        clk, rst_n, req_valid, req_ready, req_store, mem_write, mem_read, mem_half, mem_byte;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_addr, mem_wdata, mem_rdata, resp_data;
  logic        resp_valid, resp_ready, resp_misalign, resp_illegal, resp_fault, busy;
  typedef struct {
    logic [31:0] data;
    logic        mis, ill, flt;
    int          cyc, nrd, nwr;
    logic [31:0] addr;
    logic        half, bytes;
  } exp_t;
  exp_t        q[$];
  exp_t        cur;
  logic [7:0]  bmem[256];
  logic [7:0]  rmem[256];
  int          checks = 0, failures = 0, cyc = 0, nrd = 0, nwr = 0;
  bit          seeded = 0, in_resp = 0, hold_low = 0;
  logic [31:0] s_addr;
  logic        s_half, s_byte;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_half(mem_half), .mem_byte(mem_byte),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_misalign(resp_misalign), .resp_illegal(resp_illegal),
    .resp_fault(resp_fault), .busy(busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] seed(int i);
    return i == 0 ? 8'hFF : i == 1 ? 8'h54 : i == 2 ? 8'h01 : i == 3 ? 8'h02 : i == 6 ? 8'h10 : i == 7 ? 8'h82 : 8'h00;
  endfunction
  // Data memory: byte/half/word writes, registered word read
  always @(posedge clk) begin
    logic [7:0] a;
    a = mem_addr[7:0];
    if (!seeded) begin
      for (int i = 0; i < 256; i++) bmem[i] = seed(i);
      seeded = 1;
    end else if (mem_write) begin
      bmem[a] = mem_wdata[7:0];
      if (!mem_byte) bmem[a + 8'd1] = mem_wdata[15:8];
      if (!mem_byte && !mem_half) begin
        bmem[a + 8'd2] = mem_wdata[23:16];
        bmem[a + 8'd3] = mem_wdata[31:24];
      end
    end
    if (mem_read) mem_rdata <= {bmem[a + 8'd3], bmem[a + 8'd2], bmem[a + 8'd1], bmem[a]};
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int n;
    longint v;
    bit err;
    e.ill = st ? (f3 > 2) : (f3 == 3 || f3 > 5);
    e.mis = (f3[1:0] == 1 && a[0]) || (f3[1:0] == 2 && a[1:0] != 0);
    e.flt = a > 255;
    err = e.ill || e.mis || e.flt;
    n = f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
    v = 0;
    if (!err && st)
      for (int i = 0; i < n; i++) rmem[a[7:0] + 8'(i)] = wd[8*i +: 8];
    if (!err && !st) begin
      for (int i = 0; i < n; i++) v += longint'(rmem[a[7:0] + 8'(i)]) << (8 * i);
      if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v -= 64'd1 << (8 * n);
    end
    e.data  = v[31:0];
    e.cyc   = cyc + (err ? 1 : st ? 2 : 3);
    e.nrd   = (!err && !st) ? 1 : 0;
    e.nwr   = (!err && st) ? 1 : 0;
    e.addr  = a;
    e.half  = f3[1:0] == 1;
    e.bytes = f3[1:0] == 0;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input bit push);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    model(st, f3, a, wd, e);
    if (push) q.push_back(e);
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
  endtask
  initial forever begin
    @(negedge clk);
    resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  // Monitor: pops one expectation per response and checks it is held stable
  always @(negedge clk) begin
    if (!rst_n) begin
      nrd = 0; nwr = 0; in_resp = 0;
    end else begin
      if (mem_read || mem_write) begin
        chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        nrd += int'(mem_read); nwr += int'(mem_write);
        s_addr = mem_addr; s_half = mem_half; s_byte = mem_byte;
      end
      if (resp_valid && !in_resp) begin
        if (q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          cur = q.pop_front();
          chk("resp_data", resp_data, cur.data);
          chk("resp_misalign", 32'(resp_misalign), 32'(cur.mis));
          chk("resp_illegal", 32'(resp_illegal), 32'(cur.ill));
          chk("resp_fault", 32'(resp_fault), 32'(cur.flt));
          chk("latency_cycle", 32'(cyc), 32'(cur.cyc));
          chk("read_strobes", 32'(nrd), 32'(cur.nrd));
          chk("write_strobes", 32'(nwr), 32'(cur.nwr));
          if (cur.nrd + cur.nwr > 0) begin
            chk("mem_addr", s_addr, cur.addr);
            chk("mem_half", 32'(s_half), 32'(cur.half));
            chk("mem_byte", 32'(s_byte), 32'(cur.bytes));
          end
        end
        in_resp = 1; nrd = 0; nwr = 0;
      end else if (resp_valid) begin
        chk("hold_data", resp_data, cur.data);
        chk("hold_flags", {29'd0, resp_misalign, resp_illegal, resp_fault}, {29'd0, cur.mis, cur.ill, cur.flt});
        chk("hold_ready_busy", {30'd0, req_ready, busy}, 32'd1);
      end
      if (!resp_valid) in_resp = 0;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) rmem[i] = seed(i);
    rst_n = 0; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_flags", {29'd0, resp_misalign, resp_illegal, resp_fault}, 32'd0);
    chk("rst_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    chk("rst_strobes", {28'd0, mem_read, mem_write, mem_half, mem_byte}, 32'd0);
    rst_n = 1;
    issue(0, 3'b010, 32'd0, 0, 1);
    issue(0, 3'b000, 32'd0, 0, 1);
    issue(0, 3'b100, 32'd0, 0, 1);
    issue(0, 3'b001, 32'd6, 0, 1);
    issue(0, 3'b101, 32'd6, 0, 1);
    issue(1, 3'b010, 32'd16, 32'hDEADBEEF, 1);
    issue(0, 3'b010, 32'd16, 0, 1);
    issue(1, 3'b000, 32'd20, 32'h12345678, 1);
    issue(0, 3'b010, 32'd20, 0, 1);
    issue(0, 3'b010, 32'd2, 0, 1);
    issue(0, 3'b011, 32'd0, 0, 1);
    issue(0, 3'b010, 32'h100, 0, 1);
    issue(1, 3'b011, 32'h101, 0, 1);
    hold_low = 1;
    issue(0, 3'b000, 32'd7, 0, 1);
    t = 0;
    while (!resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    hold_low = 0;
    issue(0, 3'b010, 32'd0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst_capture_valid", 32'(resp_valid), 32'd0);
    chk("rst_capture_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    @(negedge clk);
    rst_n = 1;
    issue(1, 3'b010, 32'd24, 32'hCAFEF00D, 0);
    rst_n = 0;
    @(negedge clk);
    chk("rst_access_valid", 32'(resp_valid), 32'd0);
    chk("rst_access_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    issue(0, 3'b010, 32'd24, 0, 1);
    for (int k = 0; k < 250; k++) begin
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1);
    end
    t = 0;
    while ((q.size() != 0 || resp_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_queue", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
